// File: rtl/factor_pkg.sv
// Shared constants and helpers for the factorization operand path.
package factor_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  function automatic int clog2_min1(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stream_select_arbiter_rr_pick.sv
// Combinational rotate-priority picker: first asserted request at or after ptr, wrapping.
module rr_pick
  import factor_pkg::*;
#(
  parameter  int CHANNELS = 8,
  localparam int SEL_W    = clog2_min1(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [SEL_W-1:0]    ptr,
  output logic [CHANNELS-1:0] gnt_onehot,
  output logic [SEL_W-1:0]    gnt_idx,
  output logic                any
);

  int w_idx;

  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    any        = 1'b0;
    w_idx      = 0;
    for (int i = 0; i < CHANNELS; i++) begin
      // Subtract instead of modulo: ptr is always < CHANNELS, so one wrap suffices.
      w_idx = int'(ptr) + i;
      if (w_idx >= CHANNELS) w_idx = w_idx - CHANNELS;
      if (!any && req[w_idx]) begin
        any               = 1'b1;
        gnt_onehot[w_idx] = 1'b1;
        gnt_idx           = SEL_W'(w_idx);
      end
    end
  end

endmodule

// File: rtl/stream_select_arbiter.sv
// N-way valid/ready stream selector (fixed address or round-robin) with a one-deep
// registered output stage and backpressure.
module stream_select_arbiter
  import factor_pkg::*;
#(
  parameter  int SIZE     = 1,
  parameter  int CHANNELS = 8,
  localparam int SEL_W    = clog2_min1(CHANNELS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         sel_addr,
  input  logic [CHANNELS*SIZE-1:0] x_data,
  input  logic [CHANNELS-1:0]      x_valid,
  output logic [CHANNELS-1:0]      x_ready,
  output logic [SIZE-1:0]          y,
  output logic [SEL_W-1:0]         y_chan,
  output logic                     y_valid,
  input  logic                     y_ready
);

  logic [SIZE-1:0]     r_y;
  logic [SEL_W-1:0]    r_y_chan;
  logic                r_y_valid;
  logic [SEL_W-1:0]    r_rr_ptr;

  logic                w_load;
  logic [CHANNELS-1:0] w_rr_onehot;
  logic [SEL_W-1:0]    w_rr_idx;
  logic                w_rr_any;
  logic                w_cand_any;
  logic [SEL_W-1:0]    w_cand_idx;
  logic [CHANNELS-1:0] w_cand_onehot;

  rr_pick #(.CHANNELS(CHANNELS)) u_rr_pick (
    .req        (x_valid),
    .ptr        (r_rr_ptr),
    .gnt_onehot (w_rr_onehot),
    .gnt_idx    (w_rr_idx),
    .any        (w_rr_any)
  );

  assign w_load = !r_y_valid || y_ready;

  always_comb begin
    w_cand_any    = 1'b0;
    w_cand_idx    = '0;
    w_cand_onehot = '0;
    if (mode == MODE_RR) begin
      w_cand_any    = w_rr_any;
      w_cand_idx    = w_rr_idx;
      w_cand_onehot = w_rr_onehot;
    end else if (int'(sel_addr) < CHANNELS) begin
      // Guard matters only when CHANNELS is not a power of two.
      w_cand_any               = x_valid[sel_addr];
      w_cand_idx               = sel_addr;
      w_cand_onehot[sel_addr]  = x_valid[sel_addr];
    end
  end

  assign x_ready = (rst_n && w_load && w_cand_any) ? w_cand_onehot : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_y       <= '0;
      r_y_chan  <= '0;
      r_y_valid <= 1'b0;
      r_rr_ptr  <= '0;
    end else if (w_load) begin
      if (w_cand_any) begin
        r_y       <= x_data[int'(w_cand_idx)*SIZE +: SIZE];
        r_y_chan  <= w_cand_idx;
        r_y_valid <= 1'b1;
        if (mode == MODE_RR)
          r_rr_ptr <= (w_cand_idx == SEL_W'(CHANNELS-1)) ? '0 : w_cand_idx + 1'b1;
      end else begin
        r_y_valid <= 1'b0;
      end
    end
  end

  assign y       = r_y;
  assign y_chan  = r_y_chan;
  assign y_valid = r_y_valid;

endmodule

// File: tb/tb_stream_select_arbiter.sv
// Directed, table-driven bench for stream_select_arbiter (SIZE=8, CHANNELS=8).
module tb_stream_select_arbiter;

  localparam int SIZE     = 8;
  localparam int CHANNELS = 8;
  localparam int SEL_W    = 3;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     mode;
  logic [SEL_W-1:0]         sel_addr;
  logic [CHANNELS*SIZE-1:0] x_data;
  logic [CHANNELS-1:0]      x_valid;
  logic [CHANNELS-1:0]      x_ready;
  logic [SIZE-1:0]          y;
  logic [SEL_W-1:0]         y_chan;
  logic                     y_valid;
  logic                     y_ready;

  stream_select_arbiter #(.SIZE(SIZE), .CHANNELS(CHANNELS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .mode     (mode),
    .sel_addr (sel_addr),
    .x_data   (x_data),
    .x_valid  (x_valid),
    .x_ready  (x_ready),
    .y        (y),
    .y_chan   (y_chan),
    .y_valid  (y_valid),
    .y_ready  (y_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       mode;
    logic [2:0] sel;
    logic [7:0] valid;
    logic       rdy;
    logic [7:0] exp_xr;
    logic       exp_yv;
    logic [7:0] exp_y;
    logic [2:0] exp_ch;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic m, input logic [2:0] s, input logic [7:0] v, input logic r,
                     input logic [7:0] xr, input logic yv, input logic [7:0] yy,
                     input logic [2:0] ch);
    vec_t t;
    t.mode = m; t.sel = s; t.valid = v; t.rdy = r;
    t.exp_xr = xr; t.exp_yv = yv; t.exp_y = yy; t.exp_ch = ch;
    vecs.push_back(t);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic yv, input logic [7:0] yy,
                         input logic [2:0] ch);
    chk({tag, ".y_valid"}, 32'(y_valid), 32'(yv));
    chk({tag, ".y"},       32'(y),       32'(yy));
    chk({tag, ".y_chan"},  32'(y_chan),  32'(ch));
  endtask

  initial begin
    for (int k = 0; k < CHANNELS; k++) x_data[k*SIZE +: SIZE] = 8'(8'hA0 | k);
    rst_n = 1'b0; mode = 1'b0; sel_addr = 3'd0; x_valid = 8'hFF; y_ready = 1'b1;

    // Reset held 3 cycles with every channel valid.
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("rst%0d.x_ready", c), 32'(x_ready), 32'h0);
      tick();
      chk_out($sformatf("rst%0d", c), 1'b0, 8'h00, 3'd0);
    end
    rst_n = 1'b1;

    //  mode sel  valid         rdy  x_ready   yv  y      chan
    add(1'b0, 3'd5, 8'hFF,       1'b1, 8'h20, 1'b1, 8'hA5, 3'd5); // fixed ch5
    add(1'b1, 3'd0, 8'b10001001, 1'b1, 8'h01, 1'b1, 8'hA0, 3'd0); // rr 0,3,7,0,3
    add(1'b1, 3'd0, 8'b10001001, 1'b1, 8'h08, 1'b1, 8'hA3, 3'd3);
    add(1'b1, 3'd0, 8'b10001001, 1'b1, 8'h80, 1'b1, 8'hA7, 3'd7);
    add(1'b1, 3'd0, 8'b10001001, 1'b1, 8'h01, 1'b1, 8'hA0, 3'd0);
    add(1'b1, 3'd0, 8'b10001001, 1'b1, 8'h08, 1'b1, 8'hA3, 3'd3);
    for (int b = 0; b < 4; b++)                                    // backpressure
      add(1'b1, 3'd0, 8'b10001001, 1'b0, 8'h00, 1'b1, 8'hA3, 3'd3);
    add(1'b1, 3'd0, 8'b10001001, 1'b1, 8'h80, 1'b1, 8'hA7, 3'd7); // resumes at ptr 4
    add(1'b0, 3'd6, 8'hBF,       1'b1, 8'h00, 1'b0, 8'hA7, 3'd7); // fixed, ch6 idle
    add(1'b0, 3'd6, 8'hBF,       1'b1, 8'h00, 1'b0, 8'hA7, 3'd7);
    add(1'b0, 3'd2, 8'h04,       1'b0, 8'h04, 1'b1, 8'hA2, 3'd2); // load while empty
    add(1'b1, 3'd0, 8'hFF,       1'b0, 8'h00, 1'b1, 8'hA2, 3'd2);
    add(1'b1, 3'd0, 8'hFF,       1'b1, 8'h01, 1'b1, 8'hA0, 3'd0); // ptr untouched by fixed
    add(1'b1, 3'd0, 8'h00,       1'b1, 8'h00, 1'b0, 8'hA0, 3'd0); // nothing valid

    foreach (vecs[i]) begin
      mode = vecs[i].mode; sel_addr = vecs[i].sel;
      x_valid = vecs[i].valid; y_ready = vecs[i].rdy;
      #1;
      chk($sformatf("v%0d.x_ready", i), 32'(x_ready), 32'(vecs[i].exp_xr));
      tick();
      chk_out($sformatf("v%0d", i), vecs[i].exp_yv, vecs[i].exp_y, vecs[i].exp_ch);
    end

    // Reset with a held word and rr_ptr=4; after release scanning restarts at 0.
    mode = 1'b1; x_valid = 8'h18; y_ready = 1'b1;
    #1;
    chk("pre.x_ready", 32'(x_ready), 32'h08);
    tick();
    chk_out("pre", 1'b1, 8'hA3, 3'd3);
    x_valid = 8'hFF; y_ready = 1'b0;
    tick();
    rst_n = 1'b0; y_ready = 1'b1;
    #1;
    chk("midrst.x_ready", 32'(x_ready), 32'h0);
    tick();
    chk_out("midrst", 1'b0, 8'h00, 3'd0);
    rst_n = 1'b1; x_valid = 8'h22;
    #1;
    chk("post.x_ready", 32'(x_ready), 32'h02);
    tick();
    chk_out("post", 1'b1, 8'hA1, 3'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
